// File: rtl/stencil_core2d.sv
// Streaming ST-lane FP32 stencil: per-column weighted sum, accumulated over ST columns into one result per tile.
// Optional STENCIL_PARTIAL_FLUSH_EN emits a partial tile when io_in_ready falls with a tile in progress.
module stencil_core2d #(
  parameter int BW = 32,
  parameter int ST = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BW*ST-1:0] io_in_matrix,
  input  logic [BW*ST-1:0] io_in_weight,
  input  logic             io_in_ready,
  output logic             io_out_valid,
  output logic [BW-1:0]    io_out_data
);

  localparam int CW = $clog2(ST);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Simplified binary32 multiply: flush-to-zero, truncation, exponent 255 means infinity.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [7:0]        ea, eb;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic [31:0]       r;
    s  = a[31] ^ b[31];
    ea = a[30:23];
    eb = b[30:23];
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = 10'(ea) + 10'(eb) - 10'sd127;
    m  = p[45:23];
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'sd1;
    end
    if ((ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) r = QNAN;
    else if (ea == 8'hFF || eb == 8'hFF) r = {s, 8'hFF, 23'd0};
    else if (ea == 8'h00 || eb == 8'h00) r = {s, 31'd0};
    else if (e >= 10'sd255)              r = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                r = {s, 31'd0};
    else                                 r = {s, e[7:0], m};
    return r;
  endfunction

  // Simplified binary32 add; guard/round/sticky bits keep truncation exact on subtraction.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]        ea, eb, eh, el, d;
    logic [22:0]       mh, ml, m;
    logic              sh, sub;
    logic [26:0]       xh, xl, al, norm;
    logic [53:0]       sh_t;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic [31:0]       r;
    ea = a[30:23];
    eb = b[30:23];
    sh = a[31]; eh = ea; mh = a[22:0]; el = eb; ml = b[22:0];
    sub = a[31] ^ b[31];
    d = 8'd0; xh = 27'd0; xl = 27'd0; al = 27'd0; norm = 27'd0;
    sh_t = 54'd0; sum = 28'd0; lz = 5'd0; e = 10'sd0; m = 23'd0;
    r = 32'd0;
    if (ea == 8'hFF && eb == 8'hFF) begin
      r = sub ? QNAN : {a[31], 8'hFF, 23'd0};
    end else if (ea == 8'hFF) begin
      r = {a[31], 8'hFF, 23'd0};
    end else if (eb == 8'hFF) begin
      r = {b[31], 8'hFF, 23'd0};
    end else if (ea == 8'h00 && eb == 8'h00) begin
      r = {a[31] & b[31], 31'd0};
    end else if (ea == 8'h00) begin
      r = b;
    end else if (eb == 8'h00) begin
      r = a;
    end else begin
      if ({eb, b[22:0]} > {ea, a[22:0]}) begin
        sh = b[31]; eh = eb; mh = b[22:0]; el = ea; ml = a[22:0];
      end
      d  = eh - el;
      xh = {1'b1, mh, 3'b000};
      xl = {1'b1, ml, 3'b000};
      if (d > 8'd26) begin
        al = 27'd1;
      end else begin
        sh_t = {xl, 27'd0} >> d;
        al   = {sh_t[53:28], sh_t[27] | (|sh_t[26:0])};
      end
      if (!sub) begin
        sum = {1'b0, xh} + {1'b0, al};
        e   = 10'(eh);
        if (sum[27]) begin
          m = sum[26:4];
          e = e + 10'sd1;
        end else begin
          m = sum[25:3];
        end
      end else begin
        sum = {1'b0, xh} - {1'b0, al};
        for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
        norm = sum[26:0] << lz;
        m    = norm[25:3];
        e    = 10'(eh) - 10'(lz);
      end
      if (sum == 28'd0)       r = 32'd0;
      else if (e >= 10'sd255) r = {sh, 8'hFF, 23'd0};
      else if (e <= 10'sd0)   r = {sh, 31'd0};
      else                    r = {sh, e[7:0], m};
    end
    return r;
  endfunction

  logic [CW-1:0]      col_cnt;
  logic               flush_start;
  logic [BW*ST-1:0]   in_matrix_q, in_weight_q;
  logic               in_valid, in_last, in_flush;
  logic [BW-1:0]      prod_d [ST];
  logic [BW-1:0]      prod_q [ST];
  logic               p_valid, p_last, p_flush;
  logic [BW-1:0]      colsum_d, colsum_q;
  logic               s_valid, s_last, s_flush;
  logic [BW-1:0]      acc_q, acc_sum;

`ifdef STENCIL_PARTIAL_FLUSH_EN
  logic ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= io_in_ready;
  end

  // A falling io_in_ready with a tile in progress sends a flush token down behind the last column.
  assign flush_start = ready_q && !io_in_ready && (col_cnt != '0);
`else
  assign flush_start = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_cnt     <= '0;
      in_valid    <= 1'b0;
      in_last     <= 1'b0;
      in_flush    <= 1'b0;
      in_matrix_q <= '0;
      in_weight_q <= '0;
    end else begin
      in_valid <= io_in_ready;
      in_last  <= io_in_ready && (col_cnt == CW'(ST - 1));
      in_flush <= flush_start;
      if (io_in_ready) begin
        in_matrix_q <= io_in_matrix;
        in_weight_q <= io_in_weight;
        col_cnt     <= (col_cnt == CW'(ST - 1)) ? '0 : col_cnt + CW'(1);
      end else if (flush_start) begin
        col_cnt <= '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ST; i++) prod_d[i] = fp_mul(in_matrix_q[BW*i +: BW], in_weight_q[BW*i +: BW]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_flush <= 1'b0;
      for (int i = 0; i < ST; i++) prod_q[i] <= '0;
    end else begin
      p_valid <= in_valid;
      p_last  <= in_last;
      p_flush <= in_flush;
      if (in_valid) for (int i = 0; i < ST; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Fixed left-to-right reduction keeps results bit-reproducible.
  always_comb begin
    colsum_d = prod_q[0];
    for (int i = 1; i < ST; i++) colsum_d = fp_add(colsum_d, prod_q[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_valid  <= 1'b0;
      s_last   <= 1'b0;
      s_flush  <= 1'b0;
      colsum_q <= '0;
    end else begin
      s_valid <= p_valid;
      s_last  <= p_last;
      s_flush <= p_flush;
      if (p_valid) colsum_q <= colsum_d;
    end
  end

  assign acc_sum = fp_add(acc_q, colsum_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
    end else begin
      io_out_valid <= 1'b0;
      if (s_valid) begin
        if (s_last) begin
          io_out_data  <= acc_sum;
          io_out_valid <= 1'b1;
          acc_q        <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end else if (s_flush) begin
        io_out_data  <= acc_q;
        io_out_valid <= 1'b1;
        acc_q        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stencil_core2d.sv
// Directed self-checking bench for stencil_core2d; expectations adapt when STENCIL_PARTIAL_FLUSH_EN is defined.
module tb_stencil_core2d;

  localparam int BW = 32;
  localparam int ST = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [BW*ST-1:0] matrix = '0;
  logic [BW*ST-1:0] weight = '0;
  logic             ready = 1'b0;
  logic             out_valid;
  logic [BW-1:0]    out_data;

  int          checks = 0;
  int          failures = 0;
  int          edges = 0;
  int          pulses = 0;
  logic [31:0] pulse_data [16];
  int          pulse_edge [16];

  stencil_core2d #(.BW(BW), .ST(ST)) dut (
    .clock(clock),
    .reset(reset),
    .io_in_matrix(matrix),
    .io_in_weight(weight),
    .io_in_ready(ready),
    .io_out_valid(out_valid),
    .io_out_data(out_data)
  );

  always #5 clock = ~clock;

  // Advance one edge, then record any output pulse seen 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
    edges++;
    if (out_valid === 1'b1) begin
      if (pulses < 16) begin
        pulse_data[pulses] = out_data;
        pulse_edge[pulses] = edges;
      end
      pulses++;
    end
  endtask

  task automatic set_uniform(input logic [31:0] m, input logic [31:0] w);
    for (int i = 0; i < ST; i++) begin
      matrix[BW*i +: BW] = m;
      weight[BW*i +: BW] = w;
    end
  endtask

  task automatic send_column(input logic [31:0] m, input logic [31:0] w);
    set_uniform(m, w);
    ready = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    ready = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00000000", out_data); end
    reset = 1'b0;
    pulses = 0;
    idle(4);
    checks++;
    if (pulses !== 0) begin failures++; $display("[TB] FAIL reset_idle_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_single_tile();
    int last;
    pulses = 0;
    repeat (ST) send_column(32'h3F80_0000, 32'h3F80_0000);
    last = edges;
    idle(8);
    checks++;
    if (pulses !== 1) begin failures++; $display("[TB] FAIL single_count: got %0d expected 1", pulses); end
    checks++;
    if (pulse_data[0] !== 32'h41C8_0000) begin failures++; $display("[TB] FAIL single_data: got %h expected 41c80000", pulse_data[0]); end
    checks++;
    if (pulse_edge[0] !== last + 3) begin failures++; $display("[TB] FAIL single_latency: got edge %0d expected %0d", pulse_edge[0], last + 3); end
    checks++;
    if (out_data !== 32'h41C8_0000) begin failures++; $display("[TB] FAIL single_hold: got %h expected 41c80000", out_data); end
  endtask

  task automatic test_back_to_back();
    int fifth;
    pulses = 0;
    fifth = 0;
    for (int c = 0; c < 2 * ST; c++) begin
      send_column(32'h3F80_0000, 32'h3F80_0000);
      if (c == ST - 1) fifth = edges;
    end
    idle(8);
    checks++;
    if (pulses !== 2) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 2", pulses); end
    checks++;
    if (pulse_data[0] !== 32'h41C8_0000 || pulse_data[1] !== 32'h41C8_0000) begin
      failures++; $display("[TB] FAIL b2b_data: got %h %h expected 41c80000 41c80000", pulse_data[0], pulse_data[1]);
    end
    checks++;
    if (pulse_edge[0] !== fifth + 3) begin failures++; $display("[TB] FAIL b2b_first_edge: got %0d expected %0d", pulse_edge[0], fifth + 3); end
    checks++;
    if (pulse_edge[1] - pulse_edge[0] !== ST) begin
      failures++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", pulse_edge[1] - pulse_edge[0], ST);
    end
  endtask

  task automatic test_gaps();
    int before_last;
    int exp_before, exp_total;
    logic [31:0] exp_data;
`ifdef STENCIL_PARTIAL_FLUSH_EN
    exp_before = 3; exp_total = 5; exp_data = 32'hC0A0_0000;
`else
    exp_before = 0; exp_total = 1; exp_data = 32'hC1C8_0000;
`endif
    pulses = 0;
    for (int c = 0; c < ST - 1; c++) begin
      send_column(32'h4000_0000, 32'hBF00_0000);
      idle(2);
    end
    before_last = pulses;
    send_column(32'h4000_0000, 32'hBF00_0000);
    idle(8);
    checks++;
    if (before_last !== exp_before) begin failures++; $display("[TB] FAIL gaps_early_pulses: got %0d expected %0d", before_last, exp_before); end
    checks++;
    if (pulses !== exp_total) begin failures++; $display("[TB] FAIL gaps_count: got %0d expected %0d", pulses, exp_total); end
    checks++;
    if (out_data !== exp_data) begin failures++; $display("[TB] FAIL gaps_data: got %h expected %h", out_data, exp_data); end
  endtask

  task automatic test_ramp();
    logic [31:0] vals [5];
    vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
    pulses = 0;
    for (int c = 0; c < ST; c++) send_column(vals[c], 32'h3F80_0000);
    idle(8);
    checks++;
    if (pulses !== 1) begin failures++; $display("[TB] FAIL ramp_count: got %0d expected 1", pulses); end
    checks++;
    if (pulse_data[0] !== 32'h4296_0000) begin failures++; $display("[TB] FAIL ramp_data: got %h expected 42960000", pulse_data[0]); end
  endtask

  // Lane products 3, 1, -3, 2, -1 give a column sum of 2.0, so the tile is 10.0.
  task automatic test_mixed_lanes();
    logic [31:0] m [5];
    logic [31:0] w [5];
    m = '{32'h3FC0_0000, 32'h4000_0000, 32'hC040_0000, 32'h3E80_0000, 32'h4080_0000};
    w = '{32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h4100_0000, 32'hBE80_0000};
    pulses = 0;
    for (int i = 0; i < ST; i++) begin
      matrix[BW*i +: BW] = m[i];
      weight[BW*i +: BW] = w[i];
    end
    ready = 1'b1;
    repeat (ST) step();
    idle(8);
    checks++;
    if (pulses !== 1 || pulse_data[0] !== 32'h4120_0000) begin
      failures++; $display("[TB] FAIL mixed_data: got %0d pulses data %h expected 1 pulse 41200000", pulses, pulse_data[0]);
    end
  endtask

  task automatic test_reset_mid_tile();
    pulses = 0;
    repeat (3) send_column(32'h3F80_0000, 32'h3F80_0000);
    ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("[TB] FAIL midreset_outputs: got valid %b data %h expected 0 00000000", out_valid, out_data);
    end
    reset = 1'b0;
    idle(4);
    checks++;
    if (pulses !== 0) begin failures++; $display("[TB] FAIL midreset_no_pulse: got %0d expected 0", pulses); end
    repeat (ST) send_column(32'h3F80_0000, 32'h3F80_0000);
    idle(8);
    checks++;
    if (pulses !== 1) begin failures++; $display("[TB] FAIL midreset_count: got %0d expected 1", pulses); end
    checks++;
    if (pulse_data[0] !== 32'h41C8_0000) begin failures++; $display("[TB] FAIL midreset_data: got %h expected 41c80000", pulse_data[0]); end
  endtask

  task automatic test_partial();
    int last;
    pulses = 0;
    repeat (3) send_column(32'h3F80_0000, 32'h3F80_0000);
    last = edges;
    idle(10);
`ifdef STENCIL_PARTIAL_FLUSH_EN
    checks++;
    if (pulses !== 1 || pulse_data[0] !== 32'h4170_0000) begin
      failures++; $display("[TB] FAIL partial_flush: got %0d pulses data %h expected 1 pulse 41700000", pulses, pulse_data[0]);
    end
    checks++;
    if (pulse_edge[0] !== last + 4) begin failures++; $display("[TB] FAIL partial_edge: got %0d expected %0d", pulse_edge[0], last + 4); end
    pulses = 0;
    repeat (2) send_column(32'h3F80_0000, 32'h3F80_0000);
    idle(10);
    checks++;
    if (pulses !== 1 || pulse_data[0] !== 32'h4120_0000) begin
      failures++; $display("[TB] FAIL partial_second: got %0d pulses data %h expected 1 pulse 41200000", pulses, pulse_data[0]);
    end
`else
    checks++;
    if (pulses !== 0) begin failures++; $display("[TB] FAIL partial_held: got %0d pulses expected 0 (edge %0d)", pulses, last); end
    repeat (2) send_column(32'h3F80_0000, 32'h3F80_0000);
    idle(8);
    checks++;
    if (pulses !== 1 || pulse_data[0] !== 32'h41C8_0000) begin
      failures++; $display("[TB] FAIL partial_complete: got %0d pulses data %h expected 1 pulse 41c80000", pulses, pulse_data[0]);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      pulse_data[i] = 32'h0;
      pulse_edge[i] = 0;
    end
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_gaps();
    test_ramp();
    test_mixed_lanes();
    test_reset_mid_tile();
    test_partial();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
